// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: one-strobe SD command sequencer in front of sdspi.
// Writes arg and cmd, polls busy, reads data, then reports R1/data/error.
module sd_cmd_seq #(
    parameter int          BUSY_BIT   = 14,
    parameter logic [15:0] POLL_LIMIT = 16'd4095,
    parameter logic [7:0]  ACK_LIMIT  = 8'd63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [5:0]  i_cmd,
    input  logic [31:0] i_arg,
    input  logic        i_abort,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err,
    output logic [7:0]  o_r1,
    output logic [31:0] o_resp,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [1:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ARG,
        WR_CMD,
        POLL,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_POLL  = 2'b01;
    localparam logic [1:0] ERR_ACK   = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    localparam logic [1:0] ADDR_CMD  = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;

    state_t      state;
    logic [5:0]  cmd_q;
    logic [31:0] arg_q;
    logic        stb;
    logic        abort_pend;
    logic [15:0] poll_cnt;
    logic [7:0]  ack_cnt;

    logic [15:0] poll_cnt_nxt;
    logic [7:0]  ack_cnt_nxt;
    logic        ack_expire;
    logic        stop_req;
    logic        slave_busy;
    logic [31:0] cmd_word;

    // cyc and stb are one and the same strobe register
    assign o_wb_cyc = stb;
    assign o_wb_stb = stb;

    // Saturating counter steps so neither counter can ever wrap
    assign poll_cnt_nxt = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
    assign ack_cnt_nxt  = (ack_cnt == 8'hFF) ? ack_cnt : ack_cnt + 8'd1;

    // Watchdog fires on the last strobe cycle allowed without an ack
    assign ack_expire = (ack_cnt_nxt == ACK_LIMIT);

    // An abort seen now or earlier in this transaction ends it on ack
    assign stop_req   = abort_pend | i_abort;
    assign slave_busy = i_wb_data[BUSY_BIT];

    // sdspi command byte carries the 01 start/transmission prefix
    assign cmd_word = {24'h0, 2'b01, cmd_q};

    // Sequencer: all bus and result outputs are registered here
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_q      <= '0;
            arg_q      <= '0;
            stb        <= 1'b0;
            abort_pend <= 1'b0;
            poll_cnt   <= '0;
            ack_cnt    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= '0;
            o_r1       <= '0;
            o_resp     <= '0;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= '0;
            o_wb_data  <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        cmd_q      <= i_cmd;
                        arg_q      <= i_arg;
                        o_err      <= ERR_OK;
                        o_r1       <= '0;
                        o_resp     <= '0;
                        o_busy     <= 1'b1;
                        poll_cnt   <= '0;
                        ack_cnt    <= '0;
                        abort_pend <= 1'b0;
                        stb        <= 1'b1;
                        o_wb_we    <= 1'b1;
                        o_wb_addr  <= ADDR_DATA;
                        o_wb_data  <= i_arg;
                        state      <= WR_ARG;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    if (!stb) begin
                        // Gap cycle: nothing in flight, abort is immediate
                        if (i_abort) begin
                            o_err  <= ERR_ABORT;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            stb        <= 1'b1;
                            ack_cnt    <= '0;
                            abort_pend <= 1'b0;
                            unique case (state)
                                WR_ARG: begin
                                    o_wb_we   <= 1'b1;
                                    o_wb_addr <= ADDR_DATA;
                                    o_wb_data <= arg_q;
                                end
                                WR_CMD: begin
                                    o_wb_we   <= 1'b1;
                                    o_wb_addr <= ADDR_CMD;
                                    o_wb_data <= cmd_word;
                                end
                                POLL: begin
                                    o_wb_we   <= 1'b0;
                                    o_wb_addr <= ADDR_CMD;
                                    o_wb_data <= '0;
                                end
                                RD_DATA: begin
                                    o_wb_we   <= 1'b0;
                                    o_wb_addr <= ADDR_DATA;
                                    o_wb_data <= '0;
                                end
                                default: begin
                                    stb <= 1'b0;
                                end
                            endcase
                        end
                    end else if (i_wb_ack) begin
                        // Transaction complete: strobe drops for the gap
                        stb       <= 1'b0;
                        o_wb_we   <= 1'b0;
                        o_wb_addr <= '0;
                        o_wb_data <= '0;
                        unique case (state)
                            WR_ARG: begin
                                if (stop_req) begin
                                    o_err  <= ERR_ABORT;
                                    o_busy <= 1'b0;
                                    o_done <= 1'b1;
                                    state  <= DONE;
                                end else begin
                                    state <= WR_CMD;
                                end
                            end
                            WR_CMD: begin
                                if (stop_req) begin
                                    o_err  <= ERR_ABORT;
                                    o_busy <= 1'b0;
                                    o_done <= 1'b1;
                                    state  <= DONE;
                                end else begin
                                    state <= POLL;
                                end
                            end
                            POLL: begin
                                o_r1 <= i_wb_data[7:0];
                                if (stop_req) begin
                                    o_err  <= ERR_ABORT;
                                    o_busy <= 1'b0;
                                    o_done <= 1'b1;
                                    state  <= DONE;
                                end else if (!slave_busy) begin
                                    state <= RD_DATA;
                                end else if (poll_cnt_nxt == POLL_LIMIT) begin
                                    poll_cnt <= poll_cnt_nxt;
                                    o_err    <= ERR_POLL;
                                    o_busy   <= 1'b0;
                                    o_done   <= 1'b1;
                                    state    <= DONE;
                                end else begin
                                    poll_cnt <= poll_cnt_nxt;
                                end
                            end
                            RD_DATA: begin
                                o_resp <= i_wb_data;
                                o_err  <= stop_req ? ERR_ABORT : ERR_OK;
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                state  <= DONE;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end else if (ack_expire) begin
                        // Slave went silent: give up, timeout beats abort
                        stb       <= 1'b0;
                        o_wb_we   <= 1'b0;
                        o_wb_addr <= '0;
                        o_wb_data <= '0;
                        o_err     <= ERR_ACK;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        ack_cnt <= ack_cnt_nxt;
                        if (i_abort) begin
                            abort_pend <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// tb_sd_cmd_seq: directed + randomized bench for sd_cmd_seq.
// Wishbone slave model plus a transaction-level expectation model.
module tb_sd_cmd_seq;

    localparam logic [15:0] PL = 16'd4;
    localparam int          AL = 63;
    localparam int          BB = 14;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [5:0]  i_cmd;
    logic [31:0] i_arg;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_err;
    logic [7:0]  o_r1;
    logic [31:0] o_resp;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [1:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;

    sd_cmd_seq #(
        .BUSY_BIT   (BB),
        .POLL_LIMIT (PL),
        .ACK_LIMIT  (8'(AL))
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_start   (i_start),
        .i_cmd     (i_cmd),
        .i_arg     (i_arg),
        .i_abort   (i_abort),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_err     (o_err),
        .o_r1      (o_r1),
        .o_resp    (o_resp),
        .o_wb_cyc  (o_wb_cyc),
        .o_wb_stb  (o_wb_stb),
        .o_wb_we   (o_wb_we),
        .o_wb_addr (o_wb_addr),
        .o_wb_data (o_wb_data),
        .i_wb_ack  (i_wb_ack),
        .i_wb_data (i_wb_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave configuration and logs
    int          ack_dly   = 1;
    bit          noack_cmd = 1'b0;
    int          busy_left = 0;
    logic [7:0]  r1_val    = 8'h01;
    logic [31:0] resp_val  = 32'h0;
    logic [31:0] junk      = 32'h0;
    bit          lg_we[$];
    logic [1:0]  lg_addr[$];
    logic [31:0] lg_data[$];
    int          lg_len[$];
    int          last_run  = 0;
    int          unstable  = 0;
    int          cyc_bad   = 0;

    // Done monitor results
    int          done_cnt = 0;
    int          done_at  = 0;
    int unsigned t0       = 0;
    logic [1:0]  err_d;
    logic [7:0]  r1_d;
    logic [31:0] resp_d;
    logic        busy_d;
    logic        stb_d;

    // Expectations
    bit          ex_we[$];
    logic [1:0]  ex_addr[$];
    logic [31:0] ex_data[$];
    int          ex_done;
    logic [1:0]  ex_err;
    logic [7:0]  ex_r1;
    logic [31:0] ex_resp;

    int errors = 0;
    int checks = 0;

    // Wishbone slave: acks on strobe cycle ack_dly+1, serves busy polls
    initial begin : slave
        int          hi;
        logic [34:0] first;
        hi        = 0;
        first     = '0;
        i_wb_ack  = 1'b0;
        i_wb_data = '0;
        forever begin
            @(negedge clk);
            if (o_wb_cyc !== o_wb_stb) cyc_bad++;
            i_wb_ack = 1'b0;
            if (o_wb_stb === 1'b1) begin
                if (hi == 0) first = {o_wb_we, o_wb_addr, o_wb_data};
                else if ({o_wb_we, o_wb_addr, o_wb_data} !== first) unstable++;
                hi++;
                if (hi == ack_dly + 1 &&
                    !(noack_cmd && o_wb_we && o_wb_addr == 2'd0)) begin
                    i_wb_ack = 1'b1;
                    if (o_wb_we) begin
                        i_wb_data = junk;
                    end else if (o_wb_addr == 2'd0) begin
                        i_wb_data = (junk & ~32'h0000_40FF) | {24'h0, r1_val};
                        if (busy_left > 0) begin
                            i_wb_data[BB] = 1'b1;
                            busy_left--;
                        end
                    end else begin
                        i_wb_data = resp_val;
                    end
                    lg_we.push_back(o_wb_we);
                    lg_addr.push_back(o_wb_addr);
                    lg_data.push_back(o_wb_data);
                    lg_len.push_back(hi);
                end
            end else begin
                if (hi > 0) last_run = hi;
                hi = 0;
            end
        end
    end

    // Capture everything visible in the o_done cycle
    initial begin : mon
        forever begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                done_cnt++;
                done_at = int'(cyc - t0);
                err_d   = o_err;
                r1_d    = o_r1;
                resp_d  = o_resp;
                busy_d  = o_busy;
                stb_d   = o_wb_stb;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ex(input bit we, input logic [1:0] a,
                           input logic [31:0] d);
        ex_we.push_back(we);
        ex_addr.push_back(a);
        ex_data.push_back(d);
    endtask

    // Transaction-level model: each non-final transaction costs
    // d+1 strobe cycles plus one gap; the final one has no gap.
    task automatic model(input logic [5:0] cmd, input logic [31:0] arg,
                         input int nbusy, input int d, input bit noack,
                         input bit abrt);
        int polls;
        int slot;
        ex_we.delete();
        ex_addr.delete();
        ex_data.delete();
        slot    = d + 2;
        ex_r1   = 8'h00;
        ex_resp = 32'h0;
        push_ex(1'b1, 2'd1, arg);
        if (noack) begin
            ex_done = 1 + slot + AL;
            ex_err  = 2'b10;
            return;
        end
        push_ex(1'b1, 2'd0, 32'h40 | {26'h0, cmd});
        if (abrt) begin
            push_ex(1'b0, 2'd0, 32'h0);
            ex_done = 1 + 2 * slot + d + 1;
            ex_err  = 2'b11;
            ex_r1   = r1_val;
            return;
        end
        polls = (nbusy >= int'(PL)) ? int'(PL) : nbusy + 1;
        repeat (polls) push_ex(1'b0, 2'd0, 32'h0);
        ex_r1 = r1_val;
        if (nbusy >= int'(PL)) begin
            ex_done = 1 + (polls + 1) * slot + d + 1;
            ex_err  = 2'b01;
            return;
        end
        push_ex(1'b0, 2'd1, 32'h0);
        ex_resp = resp_val;
        ex_done = 1 + (polls + 2) * slot + d + 1;
        ex_err  = 2'b00;
    endtask

    task automatic run(input logic [5:0] cmd, input logic [31:0] arg,
                       input int nbusy, input int d, input bit noack,
                       input bit abrt, input bit ab_start);
        logic busy1;
        logic stb1;
        int   n;
        ack_dly   = d;
        noack_cmd = noack;
        busy_left = nbusy;
        lg_we.delete();
        lg_addr.delete();
        lg_data.delete();
        lg_len.delete();
        unstable = 0;
        cyc_bad  = 0;
        done_cnt = 0;
        last_run = 0;
        model(cmd, arg, nbusy, d, noack, abrt);
        @(negedge clk);
        t0      = cyc;
        i_start = 1'b1;
        i_cmd   = cmd;
        i_arg   = arg;
        i_abort = ab_start;
        @(negedge clk);
        i_start = 1'b0;
        i_abort = 1'b0;
        i_cmd   = 6'($urandom);
        i_arg   = $urandom;
        busy1   = o_busy;
        stb1    = o_wb_stb;
        if (abrt) begin
            for (int i = 0; i < 200 && !(o_wb_stb === 1'b1 &&
                 o_wb_we === 1'b0 && o_wb_addr === 2'd0); i++)
                @(negedge clk);
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("start_busy_stb", {62'h0, busy1, stb1}, 64'h3);
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("done_cycle", 64'(done_at), 64'(ex_done));
        chk("err", {62'h0, err_d}, {62'h0, ex_err});
        if (!abrt) chk("r1", {56'h0, r1_d}, {56'h0, ex_r1});
        chk("resp", {32'h0, resp_d}, {32'h0, ex_resp});
        chk("idle_at_done", {62'h0, busy_d, stb_d}, 64'h0);
        chk("hold", {30'h0, o_err, o_resp}, {30'h0, ex_err, ex_resp});
        chk("tx_count", 64'(lg_we.size()), 64'(ex_we.size()));
        n = (lg_we.size() < ex_we.size()) ? lg_we.size() : ex_we.size();
        for (int i = 0; i < n; i++) begin
            chk("tx_kind", {61'h0, lg_we[i], lg_addr[i]},
                {61'h0, ex_we[i], ex_addr[i]});
            if (ex_we[i]) chk("tx_data", {32'h0, lg_data[i]}, {32'h0, ex_data[i]});
        end
        chk("bus_stable", {32'(unstable), 32'(cyc_bad)}, 64'h0);
        if (noack) chk("ack_to_run", 64'(last_run), 64'(AL));
        if (abrt && lg_len.size() > 0)
            chk("abort_len", 64'(lg_len[lg_len.size() - 1]), 64'(d + 1));
    endtask

    initial begin
        reset   = 1'b0;
        i_start = 1'b0;
        i_cmd   = '0;
        i_arg   = '0;
        i_abort = 1'b0;
        @(negedge clk);
        chk("reset_a", {48'h0, o_busy, o_done, o_err, o_r1, o_wb_cyc,
            o_wb_stb, o_wb_we, o_wb_addr}, 64'h0);
        chk("reset_b", {o_resp, o_wb_data}, 64'h0);
        @(negedge clk);
        reset = 1'b1;

        // Nominal CMD8
        r1_val = 8'h01; resp_val = 32'h0000_01AA; junk = 32'h0;
        run(6'd8, 32'h0000_01AA, 0, 1, 1'b0, 1'b0, 1'b0);

        // Three busy polls before ready
        r1_val = 8'h00; resp_val = 32'hDEAD_BEEF;
        run(6'd17, 32'h1234_5678, 3, 1, 1'b0, 1'b0, 1'b0);

        // Busy never clears
        r1_val = 8'h7E; resp_val = 32'hCAFE_F00D;
        run(6'd13, 32'h0000_0000, 1000, 1, 1'b0, 1'b0, 1'b0);

        // Cmd write never acked
        r1_val = 8'h05;
        run(6'd55, 32'hA5A5_5A5A, 0, 1, 1'b1, 1'b0, 1'b0);

        // Abort during a pending poll ack
        r1_val = 8'h3C;
        run(6'd41, 32'h0F0F_0F0F, 2, 5, 1'b0, 1'b1, 1'b0);

        // Start and abort together in IDLE: start wins
        r1_val = 8'h01; resp_val = 32'h0000_01AA;
        run(6'd8, 32'h0000_01AA, 0, 1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of polling
        ack_dly = 1; noack_cmd = 1'b0; busy_left = 1000;
        r1_val = 8'hA5; done_cnt = 0;
        @(negedge clk);
        t0 = cyc; i_start = 1'b1; i_cmd = 6'd9; i_arg = 32'h1111_2222;
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < 100 && !(o_wb_stb === 1'b1 &&
             o_wb_we === 1'b0 && o_wb_addr === 2'd0); i++)
            @(negedge clk);
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_drop", {61'h0, o_wb_stb, o_wb_cyc, o_busy}, 64'h0);
        chk("async_outs_a", {48'h0, o_busy, o_done, o_err, o_r1, o_wb_cyc,
            o_wb_stb, o_wb_we, o_wb_addr}, 64'h0);
        chk("async_outs_b", {o_resp, o_wb_data}, 64'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_done_on_reset", 64'(done_cnt), 64'd0);

        r1_val = 8'h01; resp_val = 32'h0000_01AA; junk = 32'h0;
        run(6'd8, 32'h0000_01AA, 0, 1, 1'b0, 1'b0, 1'b0);

        // Randomized commands, including some poll timeouts
        for (int k = 0; k < 10; k++) begin
            r1_val   = 8'($urandom);
            resp_val = $urandom;
            junk     = $urandom;
            run(6'($urandom), $urandom, int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)), 1'b0, 1'b0,
                1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
